frame_buffer_reader: RTL and testbench
======================================

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: frame buffer address width.
REQ-002 SHALL have parameter MEM_LAT, default 2: buffer RAM read latency in clocks, legal range 1-4.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port restart, input, 1: synchronous frame restart pulse from the SPI controller.
REQ-006 SHALL have port stop_addr, input, ADDR_W: last written address from the pixel writer.
REQ-007 SHALL have port rd_req, input, 1: one-cycle byte request from downstream.
REQ-008 SHALL have port rd_data, output, 8: byte presented downstream.
REQ-009 SHALL have port rd_valid, output, 1: rd_data valid, level signal.
REQ-010 SHALL have port done, output, 1: final byte of the frame presented.
REQ-011 SHALL have port mem_addr, output, ADDR_W: buffer RAM read address.
REQ-012 SHALL have port mem_rden, output, 1: buffer RAM read enable.
REQ-013 SHALL have port mem_q, input, 8: buffer RAM read data, valid MEM_LAT clocks after mem_rden.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT_MEM, HOLD and DONE.
REQ-015 SHALL, in IDLE or HOLD on rd_req, drive mem_addr=addr_cnt, pulse mem_rden for one clock, clear rd_valid and enter WAIT_MEM.
REQ-016 SHALL count MEM_LAT clocks in WAIT_MEM, then capture mem_q into rd_data, set rd_valid and enter HOLD; request-to-valid latency SHALL be MEM_LAT+1 clocks.
REQ-017 SHALL hold rd_data and rd_valid stable in HOLD until the next rd_req or restart.
REQ-018 SHALL ignore rd_req while in WAIT_MEM or DONE.
REQ-019 SHALL latch stop_addr on the first rd_req after restart or reset, and ignore later stop_addr changes within the frame.
REQ-020 SHALL increment addr_cnt by 1 after each capture; the range is inclusive, so the byte at the latched stop_addr is the last byte read.
REQ-021 SHALL, when the captured byte is the last byte, set done together with rd_valid and enter DONE; rd_valid SHALL remain high in DONE until restart.
REQ-022 SHALL treat a latched stop_addr of 0 as a one-byte frame.
REQ-023 SHALL never wrap addr_cnt; the address after the all-ones address is unreachable because the frame terminates at stop_addr.
REQ-024 SHALL, on restart in any state, clear addr_cnt, rd_valid, done and mem_rden and enter IDLE on the next clock, abandoning any in-flight RAM read.
REQ-025 SHALL give restart priority over a simultaneous rd_req.

Reset
REQ-026 SHALL, on reset low, asynchronously force state IDLE and clear addr_cnt, latched stop_addr, the latency counter, rd_data (8'h00), rd_valid, done, mem_rden and mem_addr.
REQ-027 SHALL resume operation on the first clock edge after reset deasserts.

Configuration
REQ-028 SHALL support the macro FRAME_READER_EOI_DETECT_EN.
REQ-029 SHALL, with the macro defined, also end the frame when a captured byte 8'hD9 immediately follows a captured byte 8'hFF, asserting done with that D9 byte, whichever of EOI or stop_addr occurs first.
REQ-030 SHALL, without the macro, end the frame on stop_addr only and contain no marker-tracking logic.

Structure
REQ-031 SHALL take the state enumeration, the EOI constants 8'hFF and 8'hD9, and the default MEM_LAT from the shared package frame_reader_pkg.
REQ-032 SHALL place EOI detection in the sub-module frame_eoi_detect (inputs: byte, strobe, clear; output: eoi), instantiated only when the macro is defined.

Verification
REQ-033 SHALL verify single byte: restart, stop_addr=0, RAM[0]=8'h5A, one rd_req -> mem_rden at addr 0, rd_valid+done at request+3 clocks, rd_data=8'h5A.
REQ-034 SHALL verify full frame: stop_addr=16'h0003, RAM=11,22,33,44, four spaced rd_req -> bytes 11,22,33,44 in order, done only with 44, further rd_req issues no mem_rden.
REQ-035 SHALL verify EOI (macro on): stop_addr=16'h0010, RAM[2]=FF, RAM[3]=D9 -> done with byte D9 at addr 3; with the macro off, reading continues to addr 16'h0010.
REQ-036 SHALL verify restart mid-read: restart during WAIT_MEM -> rd_valid=0, no capture, next rd_req reads addr 0.
REQ-037 SHALL verify request collisions: rd_req during WAIT_MEM is ignored (exactly one mem_rden); restart coincident with rd_req yields IDLE and no mem_rden.
REQ-038 SHALL verify async reset: reset low mid-HOLD -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared state encoding, JPEG end-of-image marker bytes and default RAM latency.
package frame_reader_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, HOLD, DONE} state_t;
  localparam logic [7:0] EOI_LEAD = 8'hFF;
  localparam logic [7:0] EOI_MARK = 8'hD9;
  localparam int MEM_LAT_DEF = 2;
endpackage

// File: rtl/frame_eoi_detect.sv
// frame_eoi_detect: flags a captured D9 byte that directly follows a captured FF byte.
// Exists only when FRAME_READER_EOI_DETECT_EN is defined.
`ifdef FRAME_READER_EOI_DETECT_EN
module frame_eoi_detect
  import frame_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       strobe,
  input  logic       clear,
  output logic       eoi
);
  logic lead;
  always_ff @(posedge clk or negedge reset)
    if (!reset) lead <= 1'b0;
    else if (clear) lead <= 1'b0;
    else if (strobe) lead <= data == EOI_LEAD;
  assign eoi = strobe && lead && data == EOI_MARK;
endmodule
`endif

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: serves frame buffer bytes one per request up to a latched stop address.
// FRAME_READER_EOI_DETECT_EN additionally ends the frame on an FF D9 end-of-image marker.
module frame_buffer_reader
  import frame_reader_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              rd_req,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [7:0]        mem_q
);
  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_cnt, addr_n, stop_lat, stop_n, maddr_n;
  logic [7:0] data_n;
  logic valid_n, done_n, rden_n, cap, last, eoi;
  assign cap = state == WAIT_MEM && cnt == LAST_CNT && !restart;
`ifdef FRAME_READER_EOI_DETECT_EN
  frame_eoi_detect u_eoi (
    .clk   (clk),
    .reset (reset),
    .data  (mem_q),
    .strobe(cap),
    .clear (restart),
    .eoi   (eoi)
  );
`else
  assign eoi = 1'b0;
`endif
  // mem_addr still holds the address of the byte now being captured
  assign last = mem_addr == stop_lat || eoi;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_cnt;
    stop_n  = stop_lat;
    data_n  = rd_data;
    valid_n = rd_valid;
    done_n  = done;
    rden_n  = 1'b0;
    maddr_n = mem_addr;
    if (restart) begin
      state_n = IDLE;
      addr_n  = '0;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE, HOLD:
          if (rd_req) begin
            state_n = FETCH;
            rden_n  = 1'b1;
            maddr_n = addr_cnt;
            valid_n = 1'b0;
            stop_n  = state == IDLE ? stop_addr : stop_lat;
          end
        FETCH: begin
          state_n = WAIT_MEM;
          cnt_n   = '0;
        end
        WAIT_MEM:
          if (cap) begin
            data_n  = mem_q;
            valid_n = 1'b1;
            done_n  = last;
            state_n = last ? DONE : HOLD;
            addr_n  = last ? addr_cnt : addr_cnt + 1'b1;
          end else cnt_n = cnt + 2'd1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_cnt <= '0;
      stop_lat <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      mem_rden <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_cnt <= addr_n;
      stop_lat <= stop_n;
      rd_data  <= data_n;
      rd_valid <= valid_n;
      done     <= done_n;
      mem_rden <= rden_n;
      mem_addr <= maddr_n;
    end
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: directed checks of frame_buffer_reader against a two-stage RAM model.
module tb_frame_buffer_reader;
  localparam int LAT = 2;
  logic clk = 1'b0, reset = 1'b0, restart = 1'b0, rd_req = 1'b0;
  logic [15:0] stop_addr = '0;
  logic [7:0] rd_data, mem_q;
  logic rd_valid, done, mem_rden;
  logic [15:0] mem_addr;
  logic [7:0] ram [32];
  logic [7:0] pipe [LAT];
  int n_vec = 0, n_bad = 0, rden_cnt = 0, base, lat, reads;
  logic [15:0] rden_addr = '0;
  logic [7:0] prev;

  frame_buffer_reader dut (
    .clk(clk), .reset(reset), .restart(restart), .stop_addr(stop_addr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  always #5 clk = ~clk;
  assign mem_q = pipe[LAT-1];
  always @(posedge clk) begin
    if (mem_rden) begin
      rden_cnt++;
      rden_addr = mem_addr;
    end
    pipe[0] <= ram[mem_addr[4:0]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic request(output int n);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    repeat (2) tick();
    check("rst_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_rden", mem_rden, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", rd_data, 0);
    reset = 1'b1;
    // single-byte frame
    ram[0] = 8'h5A;
    stop_addr = 16'h0000;
    do_restart();
    base = rden_cnt;
    request(lat);
    check("sb_lat", lat, 3);
    check("sb_rden", rden_cnt - base, 1);
    check("sb_addr", rden_addr, 0);
    check("sb_data", rd_data, 8'h5A);
    check("sb_done", done, 1);
    // four-byte frame, stop_addr changed after latch
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    stop_addr = 16'h0003;
    do_restart();
    check("rs_valid", rd_valid, 0);
    check("rs_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      request(lat);
      stop_addr = 16'h0000;
      repeat (2) tick();
      check("ff_lat", lat, 3);
      check("ff_data", rd_data, 8'h11 * (i + 1));
      check("ff_done", done, i == 3);
      check("ff_valid", rd_valid, 1);
    end
    base = rden_cnt;
    request(lat);
    repeat (4) tick();
    check("ff_extra_rden", rden_cnt - base, 0);
    check("ff_extra_valid", rd_valid, 1);
    check("ff_extra_data", rd_data, 8'h44);
    // FF D9 marker inside a 17-byte frame
    for (int i = 0; i < 32; i++) ram[i] = 8'(i);
    ram[2] = 8'hFF; ram[3] = 8'hD9;
    stop_addr = 16'h0010;
    do_restart();
    reads = 0;
    do begin
      request(lat);
      reads++;
    end while (!done && reads < 20);
`ifdef FRAME_READER_EOI_DETECT_EN
    check("eoi_reads", reads, 4);
    check("eoi_data", rd_data, 8'hD9);
    check("eoi_addr", rden_addr, 16'h0003);
`else
    check("eoi_reads", reads, 17);
    check("eoi_data", rd_data, 8'h10);
    check("eoi_addr", rden_addr, 16'h0010);
`endif
    check("eoi_done", done, 1);
    // restart while the RAM read is in flight
    ram[0] = 8'hAA; ram[1] = 8'hBB;
    stop_addr = 16'h0005;
    do_restart();
    prev = rd_data;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    do_restart();
    repeat (3) tick();
    check("mid_valid", rd_valid, 0);
    check("mid_data", rd_data, prev);
    request(lat);
    check("mid_addr", rden_addr, 0);
    check("mid_rdata", rd_data, 8'hAA);
    // rd_req held through FETCH and WAIT_MEM
    do_restart();
    base = rden_cnt;
    rd_req = 1'b1;
    repeat (4) tick();
    rd_req = 1'b0;
    tick();
    check("col_rden", rden_cnt - base, 1);
    check("col_valid", rd_valid, 1);
    check("col_data", rd_data, 8'hAA);
    // restart together with rd_req
    base = rden_cnt;
    restart = 1'b1;
    rd_req = 1'b1;
    tick();
    restart = 1'b0;
    rd_req = 1'b0;
    repeat (3) tick();
    check("coin_rden", rden_cnt - base, 0);
    check("coin_valid", rd_valid, 0);
    request(lat);
    check("coin_addr", rden_addr, 0);
    request(lat);
    check("hold_data", rd_data, 8'hBB);
    check("hold_addr", mem_addr, 1);
    // asynchronous reset in the middle of HOLD
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("ar_valid", rd_valid, 0);
    check("ar_data", rd_data, 0);
    check("ar_addr", mem_addr, 0);
    check("ar_done", done, 0);
    check("ar_rden", mem_rden, 0);
    @(negedge clk);
    reset = 1'b1;
    request(lat);
    check("ar_resume_lat", lat, 3);
    check("ar_resume_data", rd_data, 8'hAA);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
